// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and helpers for the SPI DAC master
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } spi_state_e;

  function automatic int frame_w(input int cmd_w, input int data_w);
    return cmd_w + data_w;
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// rtl/spi_clk_div.sv - half-period tick generator for sclk
module spi_clk_div #(
  parameter int CLK_DIV = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == CW'(CLK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_dac_master.sv
// rtl/spi_dac_master.sv - mode-0 SPI master framing {cmd, data} under cs for a serial DAC
module spi_dac_master
  import spi_pkg::*;
#(
  parameter int DATA_W    = 12,
  parameter int CMD_W     = 4,
  parameter int CLK_DIV   = 50,
  parameter int CS_GAP    = 2,
  parameter int MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              newd,
  input  logic [CMD_W-1:0]  cmd_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready,
  output logic              done,
  output logic              cs,
  output logic              sclk,
  output logic              mosi
);

  localparam int FW = frame_w(CMD_W, DATA_W);
  localparam int BW = $clog2(FW);
  localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

  spi_state_e    state_q, state_d;
  logic [FW-1:0] shreg_q, shreg_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic          sclk_q, sclk_d;
  logic          cs_q, cs_d;
  logic          mosi_q, mosi_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;

  logic          div_clr;
  logic          div_en;
  logic          tick;
  logic [FW-1:0] frame_in;

  assign frame_in = {cmd_in, data_in};
  assign div_en   = (state_q != IDLE);

  spi_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_div (
    .clk (clk),
    .rst (rst),
    .clr (div_clr),
    .en  (div_en),
    .tick(tick)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    sclk_d    = sclk_q;
    cs_d      = cs_q;
    mosi_d    = mosi_q;
    ready_d   = ready_q;
    done_d    = 1'b0;
    div_clr   = 1'b0;

    case (state_q)
      IDLE: begin
        if (newd && ready_q) begin
          shreg_d   = frame_in;
          cs_d      = 1'b0;
          mosi_d    = (MSB_FIRST != 0) ? frame_in[FW-1] : frame_in[0];
          bit_cnt_d = '0;
          div_clr   = 1'b1;
          ready_d   = 1'b0;
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        if (tick) begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_cnt_q == BW'(FW - 1)) begin
              cs_d      = 1'b1;
              mosi_d    = 1'b0;
              div_clr   = 1'b1;
              gap_cnt_d = '0;
              state_d   = GAP;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
              // mosi changes only on the falling edge so the DAC sees it stable at the rise
              if (MSB_FIRST != 0) begin
                shreg_d = shreg_q << 1;
                mosi_d  = shreg_q[FW-2];
              end else begin
                shreg_d = shreg_q >> 1;
                mosi_d  = shreg_q[1];
              end
            end
          end
        end
      end

      GAP: begin
        if (tick) begin
          if (gap_cnt_q == GW'(CS_GAP - 1)) begin
            ready_d   = 1'b1;
            done_d    = 1'b1;
            gap_cnt_d = '0;
            state_d   = IDLE;
          end else begin
            gap_cnt_d = gap_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b1;
      mosi_q    <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      sclk_q    <= sclk_d;
      cs_q      <= cs_d;
      mosi_q    <= mosi_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
    end
  end

  assign ready = ready_q;
  assign done  = done_q;
  assign cs    = cs_q;
  assign sclk  = sclk_q;
  assign mosi  = mosi_q;

endmodule

// File: tb/tb_spi_dac_master.sv
// tb/tb_spi_dac_master.sv - directed bench: inst 0 MSB/div2, inst 1 LSB/div2, inst 2 MSB/div1
module tb_spi_dac_master;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  newd_v;
  logic [3:0]  cmd;
  logic [11:0] data;
  wire  [2:0]  ready_v, done_v, cs_v, sclk_v, mosi_v;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    spi_dac_master #(
      .DATA_W   (12),
      .CMD_W    (4),
      .CLK_DIV  ((g == 2) ? 1 : 2),
      .CS_GAP   (2),
      .MSB_FIRST((g == 1) ? 0 : 1)
    ) u_dut (
      .clk    (clk),
      .rst    (rst),
      .newd   (newd_v[g]),
      .cmd_in (cmd),
      .data_in(data),
      .ready  (ready_v[g]),
      .done   (done_v[g]),
      .cs     (cs_v[g]),
      .sclk   (sclk_v[g]),
      .mosi   (mosi_v[g])
    );
  end

  // i counts negedge samples after the accept edge; sample i reflects edge t0+i
  task automatic send_frame(input int s, input logic [3:0] c, input logic [11:0] d,
                            output logic [15:0] cap, output int rises, output int first_rise,
                            output int cs_lo, output int done_at,
                            output logic done_after, output logic ready_after);
    logic prev;
    prev = 1'b0; cap = '0; rises = 0; first_rise = -1; cs_lo = 0; done_at = -1;
    @(negedge clk);
    cmd = c; data = d; newd_v[s] = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (i == 0) newd_v[s] = 1'b0;
      if (sclk_v[s] && !prev) begin
        cap = {cap[14:0], mosi_v[s]};
        rises++;
        if (first_rise < 0) first_rise = i;
      end
      prev = sclk_v[s];
      if (!cs_v[s]) cs_lo++;
      if (done_v[s]) begin
        done_at = i;
        break;
      end
    end
    @(negedge clk);
    done_after  = done_v[s];
    ready_after = ready_v[s];
  endtask

  task automatic test_reset();
    rst = 1'b1; newd_v = '0; cmd = '0; data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (cs_v !== 3'b111) begin failures++; $display("FAIL reset_cs got=%b exp=111", cs_v); end
    checks++; if (sclk_v !== 3'b000) begin failures++; $display("FAIL reset_sclk got=%b exp=000", sclk_v); end
    checks++; if (mosi_v !== 3'b000) begin failures++; $display("FAIL reset_mosi got=%b exp=000", mosi_v); end
    checks++; if (ready_v !== 3'b111) begin failures++; $display("FAIL reset_ready got=%b exp=111", ready_v); end
    checks++; if (done_v !== 3'b000) begin failures++; $display("FAIL reset_done got=%b exp=000", done_v); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_msb_frame();
    logic [15:0] cap; int rises, fr, cs_lo, dn; logic da, ra;
    send_frame(0, 4'h3, 12'hA5C, cap, rises, fr, cs_lo, dn, da, ra);
    checks++; if (cap !== 16'h3A5C) begin failures++; $display("FAIL msb_bits got=%h exp=3a5c", cap); end
    checks++; if (rises !== 16) begin failures++; $display("FAIL msb_rises got=%0d exp=16", rises); end
    checks++; if (fr !== 2) begin failures++; $display("FAIL msb_first_rise got=%0d exp=2", fr); end
    checks++; if (cs_lo !== 64) begin failures++; $display("FAIL msb_cs_low got=%0d exp=64", cs_lo); end
    checks++; if (dn !== 68) begin failures++; $display("FAIL msb_done_at got=%0d exp=68", dn); end
    checks++; if (da !== 1'b0) begin failures++; $display("FAIL msb_done_width got=%b exp=0", da); end
    checks++; if (ra !== 1'b1) begin failures++; $display("FAIL msb_ready_after got=%b exp=1", ra); end
  endtask

  task automatic test_lsb_frame();
    logic [15:0] cap; int rises, fr, cs_lo, dn; logic da, ra;
    // frame 16'h0001 sent bit 0 first: only the first sampled bit is 1
    send_frame(1, 4'h0, 12'h001, cap, rises, fr, cs_lo, dn, da, ra);
    checks++; if (cap !== 16'h8000) begin failures++; $display("FAIL lsb_bits_a got=%h exp=8000", cap); end
    checks++; if (rises !== 16) begin failures++; $display("FAIL lsb_rises_a got=%0d exp=16", rises); end
    checks++; if (dn !== 68) begin failures++; $display("FAIL lsb_done_at got=%0d exp=68", dn); end
    // frame 16'h1002: bits 1 and 12 set, arriving 2nd and 13th
    send_frame(1, 4'h1, 12'h002, cap, rises, fr, cs_lo, dn, da, ra);
    checks++; if (cap !== 16'h4008) begin failures++; $display("FAIL lsb_bits_b got=%h exp=4008", cap); end
    checks++; if (rises !== 16) begin failures++; $display("FAIL lsb_rises_b got=%0d exp=16", rises); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] cap; logic prev; int dones, d1, d2, gap_hi;
    cap = '0; prev = 1'b0; dones = 0; d1 = -1; d2 = -1; gap_hi = 0;
    @(negedge clk);
    cmd = 4'h0; data = 12'h111; newd_v[0] = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (i == 0) data = 12'h222;
      if (i == 69) newd_v[0] = 1'b0;
      if (sclk_v[0] && !prev) cap = {cap[30:0], mosi_v[0]};
      prev = sclk_v[0];
      if (i < 100 && cs_v[0]) gap_hi++;
      if (done_v[0]) begin
        dones++;
        if (dones == 1) d1 = i;
        else begin
          d2 = i;
          break;
        end
      end
    end
    newd_v[0] = 1'b0;
    checks++; if (cap !== 32'h0111_0222) begin failures++; $display("FAIL b2b_bits got=%h exp=01110222", cap); end
    checks++; if (dones !== 2) begin failures++; $display("FAIL b2b_dones got=%0d exp=2", dones); end
    checks++; if (d1 !== 68) begin failures++; $display("FAIL b2b_done1 got=%0d exp=68", d1); end
    // the second accept happens on the edge after done is seen, so one frame every 69 cycles
    checks++; if (d2 !== 137) begin failures++; $display("FAIL b2b_done2 got=%0d exp=137", d2); end
    checks++; if (gap_hi !== 5) begin failures++; $display("FAIL b2b_cs_gap got=%0d exp=5", gap_hi); end
    @(negedge clk);
  endtask

  task automatic test_ignored_newd();
    logic [15:0] cap; logic prev; int dones, dn, late_lo;
    cap = '0; prev = 1'b0; dones = 0; dn = -1; late_lo = 0;
    @(negedge clk);
    cmd = 4'h0; data = 12'h000; newd_v[0] = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i == 0) newd_v[0] = 1'b0;
      if (i == 10) begin newd_v[0] = 1'b1; data = 12'hFFF; end
      if (i == 11) newd_v[0] = 1'b0;
      if (sclk_v[0] && !prev) cap = {cap[14:0], mosi_v[0]};
      prev = sclk_v[0];
      if (done_v[0]) begin dones++; dn = i; end
      if (dones > 0 && !cs_v[0]) late_lo++;
    end
    checks++; if (cap !== 16'h0000) begin failures++; $display("FAIL ign_bits got=%h exp=0000", cap); end
    checks++; if (dn !== 68) begin failures++; $display("FAIL ign_done_at got=%0d exp=68", dn); end
    checks++; if (dones !== 1) begin failures++; $display("FAIL ign_dones got=%0d exp=1", dones); end
    checks++; if (late_lo !== 0) begin failures++; $display("FAIL ign_extra_frame got=%0d exp=0", late_lo); end
  endtask

  task automatic test_rst_mid_frame();
    logic prev; int rises, bad; logic saw_done;
    logic [15:0] cap; int r2, fr, cs_lo, dn; logic da, ra;
    prev = 1'b0; rises = 0; bad = 0; saw_done = 1'b0;
    @(negedge clk);
    cmd = 4'h3; data = 12'hA5C; newd_v[0] = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (i == 0) newd_v[0] = 1'b0;
      if (sclk_v[0] && !prev) rises++;
      prev = sclk_v[0];
      if (done_v[0]) saw_done = 1'b1;
      if (rises == 5) break;
    end
    checks++; if (rises !== 5) begin failures++; $display("FAIL rst_reach_rise5 got=%0d exp=5", rises); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (cs_v[0] !== 1'b1) begin failures++; $display("FAIL rst_cs got=%b exp=1", cs_v[0]); end
    checks++; if (sclk_v[0] !== 1'b0) begin failures++; $display("FAIL rst_sclk got=%b exp=0", sclk_v[0]); end
    checks++; if (mosi_v[0] !== 1'b0) begin failures++; $display("FAIL rst_mosi got=%b exp=0", mosi_v[0]); end
    checks++; if (ready_v[0] !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", ready_v[0]); end
    rst = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done_v[0] || !cs_v[0] || sclk_v[0]) bad++;
    end
    checks++; if (saw_done || bad != 0) begin failures++; $display("FAIL rst_no_done got=%0d exp=0", bad + int'(saw_done)); end
    send_frame(0, 4'h3, 12'hA5C, cap, r2, fr, cs_lo, dn, da, ra);
    checks++; if (cap !== 16'h3A5C) begin failures++; $display("FAIL rst_fresh_bits got=%h exp=3a5c", cap); end
    checks++; if (dn !== 68) begin failures++; $display("FAIL rst_fresh_done got=%0d exp=68", dn); end
  endtask

  task automatic test_div1();
    logic [15:0] cap; int rises, fr, cs_lo, dn; logic da, ra;
    send_frame(2, 4'h5, 12'h3C1, cap, rises, fr, cs_lo, dn, da, ra);
    checks++; if (cap !== 16'h53C1) begin failures++; $display("FAIL div1_bits got=%h exp=53c1", cap); end
    checks++; if (rises !== 16) begin failures++; $display("FAIL div1_rises got=%0d exp=16", rises); end
    checks++; if (fr !== 1) begin failures++; $display("FAIL div1_first_rise got=%0d exp=1", fr); end
    checks++; if (cs_lo !== 32) begin failures++; $display("FAIL div1_cs_low got=%0d exp=32", cs_lo); end
    checks++; if (dn !== 34) begin failures++; $display("FAIL div1_done_at got=%0d exp=34", dn); end
    checks++; if (da !== 1'b0) begin failures++; $display("FAIL div1_done_width got=%b exp=0", da); end
  endtask

  initial begin
    test_reset();
    test_msb_frame();
    test_lsb_frame();
    test_back_to_back();
    test_ignored_newd();
    test_rst_mid_frame();
    test_div1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
